// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-load scoreboard for an in-order pipeline.
// Tracks outstanding long-latency loads and flags read-after-write hazards and
// pending-capacity stalls for the instruction in decode. A writeback in the
// current cycle bypasses its register. Stall length and writeback misuse are
// also reported.
module hazard_scoreboard #(
  parameter int CORE            = 0,
  parameter int REG_BITS        = 5,
  parameter int MAX_PENDING     = 4,
  parameter int STALL_TIMEOUT   = 255,
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000,
  localparam int REG_COUNT      = 2 ** REG_BITS,
  localparam int CNT_W          = $clog2(MAX_PENDING + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic                 issue_load,
  input  logic [REG_BITS-1:0]  issue_rd,
  input  logic [REG_BITS-1:0]  rs1,
  input  logic [REG_BITS-1:0]  rs2,
  input  logic                 rs1_used,
  input  logic                 rs2_used,
  input  logic                 wb_valid,
  input  logic [REG_BITS-1:0]  wb_rd,
  input  logic                 scan,
  output logic                 raw_hazard,
  output logic                 full_hazard,
  output logic                 stall,
  output logic [REG_COUNT-1:0] pending_mask,
  output logic [CNT_W-1:0]     pending_count,
  output logic [31:0]          stall_cycles,
  output logic                 stall_timeout,
  output logic                 wb_error
);

  logic [REG_COUNT-1:0] pending_r;
  logic [CNT_W-1:0]     count_r;
  logic [31:0]          stall_cycles_r;
  logic                 stall_timeout_r;
  logic                 wb_error_r;
  logic [31:0]          cycle_r;

  logic [REG_COUNT-1:0] wb_vec_s;
  logic [REG_COUNT-1:0] eff_pending_s;
  logic [REG_COUNT-1:0] set_vec_s;
  logic [REG_COUNT-1:0] pending_next_s;
  logic [CNT_W-1:0]     count_next_s;
  logic [31:0]          stall_cycles_next_s;
  logic                 clr_s;
  logic                 raw_s;
  logic                 full_s;
  logic                 stall_s;
  logic                 set_req_s;
  logic                 set_new_s;
  logic                 timeout_next_s;
  logic                 wb_error_next_s;

  // Hazard detection, acceptance and next-state computation for the scoreboard.
  always_comb begin
    wb_vec_s            = '0;
    set_vec_s           = '0;
    eff_pending_s       = '0;
    clr_s               = 1'b0;
    raw_s               = 1'b0;
    full_s              = 1'b0;
    stall_s             = 1'b0;
    set_req_s           = 1'b0;
    set_new_s           = 1'b0;
    pending_next_s      = pending_r;
    count_next_s        = count_r;
    stall_cycles_next_s = 32'd0;
    timeout_next_s      = stall_timeout_r;
    wb_error_next_s     = wb_error_r;

    if (wb_valid) begin
      wb_vec_s = REG_COUNT'(1'b1) << wb_rd;
    end else begin
      wb_vec_s = '0;
    end
    // x0 is never pending, so a writeback to x0 never counts as a clear.
    clr_s         = wb_valid & pending_r[wb_rd];
    eff_pending_s = pending_r & ~wb_vec_s;

    raw_s  = issue_valid & ((rs1_used & eff_pending_s[rs1]) | (rs2_used & eff_pending_s[rs2]));
    full_s = issue_valid & issue_load & (issue_rd != {REG_BITS{1'b0}}) &
             ((count_r - CNT_W'(clr_s)) == CNT_W'(MAX_PENDING));
    stall_s = raw_s | full_s;

    set_req_s = issue_valid & ~stall_s & issue_load & (issue_rd != {REG_BITS{1'b0}});
    // Re-issuing to a register that stays pending does not add to the count.
    set_new_s = set_req_s & ~eff_pending_s[issue_rd];
    if (set_req_s) begin
      set_vec_s = REG_COUNT'(1'b1) << issue_rd;
    end else begin
      set_vec_s = '0;
    end

    // Clear first, then set: a same-edge set and clear leaves the bit set.
    pending_next_s = (pending_r & ~wb_vec_s) | set_vec_s;
    count_next_s   = count_r + CNT_W'(set_new_s) - CNT_W'(clr_s);

    if (wb_valid & ~clr_s) begin
      wb_error_next_s = 1'b1;
    end else begin
      wb_error_next_s = wb_error_r;
    end

    if (stall_s) begin
      if (stall_cycles_r != 32'hFFFF_FFFF) begin
        stall_cycles_next_s = stall_cycles_r + 32'd1;
      end else begin
        stall_cycles_next_s = stall_cycles_r;
      end
      if (stall_cycles_next_s >= 32'(STALL_TIMEOUT)) begin
        timeout_next_s = 1'b1;
      end else begin
        timeout_next_s = stall_timeout_r;
      end
    end else begin
      stall_cycles_next_s = 32'd0;
      timeout_next_s      = stall_timeout_r;
    end
  end

  // Scoreboard, stall statistics, sticky flags and cycle counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_r       <= '0;
      count_r         <= '0;
      stall_cycles_r  <= 32'd0;
      stall_timeout_r <= 1'b0;
      wb_error_r      <= 1'b0;
      cycle_r         <= 32'd0;
    end else begin
      pending_r       <= pending_next_s;
      count_r         <= count_next_s;
      stall_cycles_r  <= stall_cycles_next_s;
      stall_timeout_r <= timeout_next_s;
      wb_error_r      <= wb_error_next_s;
      cycle_r         <= cycle_r + 32'd1;
    end
  end

  assign raw_hazard    = raw_s;
  assign full_hazard   = full_s;
  assign stall         = stall_s;
  assign pending_mask  = pending_r;
  assign pending_count = count_r;
  assign stall_cycles  = stall_cycles_r;
  assign stall_timeout = stall_timeout_r;
  assign wb_error      = wb_error_r;

`ifndef SYNTHESIS
  // Debug trace of every input and output inside the configured cycle window.
  always_ff @(posedge clock) begin
    if (scan && ($signed({32'd0, cycle_r}) >= longint'(SCAN_CYCLES_MIN)) &&
        ($signed({32'd0, cycle_r}) <= longint'(SCAN_CYCLES_MAX))) begin
      $display("scan core=%0d cycle=%0d iv=%0b ild=%0b ird=%0d rs1=%0d/%0b rs2=%0d/%0b wb=%0b/%0d raw=%0b full=%0b stall=%0b mask=%0h cnt=%0d sc=%0d to=%0b wberr=%0b",
               CORE, cycle_r, issue_valid, issue_load, issue_rd, rs1, rs1_used, rs2, rs2_used,
               wb_valid, wb_rd, raw_s, full_s, stall_s, pending_r, count_r, stall_cycles_r,
               stall_timeout_r, wb_error_r);
    end else begin
    end
  end
`endif

endmodule
